// File: rtl/timing_sequencer.sv
// Clock-divider sequencer: sample, tick and song-step strobes plus
// a 16-step note pattern played on each song step.
module timing_sequencer #(
    parameter int unsigned SAMPLE_DIV   = 256,
    parameter int unsigned TICK_DIV     = 128,
    parameter int unsigned SONG_DIV     = 6,
    parameter int unsigned PATTERN_LEN  = 16,
    parameter logic [15:0] PATTERN_INIT = 16'h1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        restart,
    input  logic        pat_load,
    input  logic [15:0] pat_data,
    output logic        sample_clk,
    output logic        tick_clk,
    output logic        song_clk,
    output logic        note_trigger,
    output logic [3:0]  step_idx
);

    localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (SONG_DIV > 1) ? $clog2(SONG_DIV) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [GW-1:0] G_LAST = GW'(SONG_DIV - 1);
    localparam logic [GW-1:0] G_ONE  = GW'(1);
    localparam logic [3:0]    P_LAST = 4'(PATTERN_LEN - 1);

    logic [SW-1:0] smp_cnt_q, smp_cnt_d;
    logic [TW-1:0] tck_cnt_q, tck_cnt_d;
    logic [GW-1:0] sng_cnt_q, sng_cnt_d;
    logic [3:0]    step_q, step_d;
    logic          smp_q, smp_d;
    logic          tck_q, tck_d;
    logic          sng_q, sng_d;
    logic          note_q, note_d;
    logic [15:0]   pattern_q;
    logic          run;

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= PATTERN_INIT;
        end else if (pat_load) begin
            pattern_q <= pat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            smp_cnt_q <= '0;
            tck_cnt_q <= '0;
            sng_cnt_q <= '0;
            step_q    <= '0;
            smp_q     <= 1'b0;
            tck_q     <= 1'b0;
            sng_q     <= 1'b0;
            note_q    <= 1'b0;
        end else begin
            smp_cnt_q <= smp_cnt_d;
            tck_cnt_q <= tck_cnt_d;
            sng_cnt_q <= sng_cnt_d;
            step_q    <= step_d;
            smp_q     <= smp_d;
            tck_q     <= tck_d;
            sng_q     <= sng_d;
            note_q    <= note_d;
        end
    end

    // Strobe registers are pending events: held while frozen and
    // consumed in the next enabled cycle, so no event is ever lost.
    always_comb begin
        smp_cnt_d = smp_cnt_q;
        tck_cnt_d = tck_cnt_q;
        sng_cnt_d = sng_cnt_q;
        step_d    = step_q;
        smp_d     = smp_q;
        tck_d     = tck_q;
        sng_d     = sng_q;
        note_d    = note_q;
        if (enable) begin
            smp_cnt_d = (smp_cnt_q == S_LAST) ? '0 : smp_cnt_q + S_ONE;
            smp_d     = (smp_cnt_q == S_LAST);
            tck_d     = 1'b0;
            sng_d     = 1'b0;
            note_d    = 1'b0;
            if (smp_q) begin
                if (tck_cnt_q == T_LAST) begin
                    tck_cnt_d = '0;
                    tck_d     = 1'b1;
                    sng_d     = (sng_cnt_q == '0);
                    note_d    = (sng_cnt_q == '0) && pattern_q[step_q];
                end else begin
                    tck_cnt_d = tck_cnt_q + T_ONE;
                end
            end
            if (tck_q) begin
                sng_cnt_d = (sng_cnt_q == G_LAST) ? '0 : sng_cnt_q + G_ONE;
            end
            if (sng_q) begin
                step_d = (step_q == P_LAST) ? '0 : step_q + 4'd1;
            end
        end
    end

    assign run = enable && !rst && !restart;

    always_comb begin
        sample_clk   = smp_q && run;
        tick_clk     = tck_q && run;
        song_clk     = sng_q && run;
        note_trigger = note_q && run;
        step_idx     = (rst || restart) ? 4'd0 : step_q;
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench for timing_sequencer with small dividers.
module tb_timing_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic        pat_load = 1'b0;
    logic [15:0] pat_data = 16'h0;
    logic        sample_clk, tick_clk, song_clk, note_trigger;
    logic [3:0]  step_idx;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    timing_sequencer #(
        .SAMPLE_DIV(4),
        .TICK_DIV(2),
        .SONG_DIV(3),
        .PATTERN_LEN(4),
        .PATTERN_INIT(16'h0005)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .restart(restart),
        .pat_load(pat_load),
        .pat_data(pat_data),
        .sample_clk(sample_clk),
        .tick_clk(tick_clk),
        .song_clk(song_clk),
        .note_trigger(note_trigger),
        .step_idx(step_idx)
    );

    // Reference timing for SAMPLE_DIV=4, TICK_DIV=2, SONG_DIV=3,
    // PATTERN_LEN=4, as a function of enabled cycles since reset.
    function automatic logic [7:0] exp_at(input int eff,
                                          input logic [15:0] pat);
        logic s, t, g, n;
        int k, ns;
        logic [3:0] st;
        s = (eff >= 4) && (eff % 4 == 0);
        t = (eff >= 9) && ((eff - 9) % 8 == 0);
        g = (eff >= 9) && ((eff - 9) % 24 == 0);
        n = 1'b0;
        if (g) begin
            k = (eff - 9) / 24;
            n = pat[k % 4];
        end
        ns = (eff <= 9) ? 0 : (eff - 10) / 24 + 1;
        st = 4'(ns % 4);
        return {st, s, t, g, n};
    endfunction

    function automatic logic [7:0] observed();
        return {step_idx, sample_clk, tick_clk, song_clk, note_trigger};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        restart = 1'b0;
        pat_load = 1'b0;
        pat_data = 16'h0;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset();
        logic [7:0] got, exp;
        rst = 1'b1;
        enable = 1'b1;
        pat_load = 1'b1;
        pat_data = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            sb_q.push_back(8'h00);
            @(negedge clk);
            got = observed();
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset c=%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
        pat_load = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] got, exp;
        do_reset();
        for (int c = 0; c <= 90; c++) begin
            rst = 1'b0;
            enable = 1'b1;
            sb_q.push_back(exp_at(c, 16'h0005));
            @(negedge clk);
            got = observed();
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_freeze();
        logic [7:0] got, exp, e;
        int eff;
        do_reset();
        eff = 0;
        for (int c = 0; c <= 70; c++) begin
            rst = 1'b0;
            enable = !(c >= 9 && c <= 13);
            e = exp_at(eff, 16'h0005);
            if (enable) begin
                sb_q.push_back(e);
                eff++;
            end else begin
                sb_q.push_back({e[7:4], 4'b0000});
            end
            @(negedge clk);
            got = observed();
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL freeze c=%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_restart();
        logic [7:0] got, exp;
        do_reset();
        for (int c = 0; c <= 64; c++) begin
            rst = 1'b0;
            enable = 1'b1;
            pat_load = (c == 15);
            pat_data = 16'hFFFF;
            restart = (c == 20);
            if (c < 20) sb_q.push_back(exp_at(c, 16'h0005));
            else if (c == 20) sb_q.push_back(8'h00);
            else sb_q.push_back(exp_at(c - 21, 16'hFFFF));
            @(negedge clk);
            got = observed();
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL restart c=%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
        restart = 1'b0;
        pat_load = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, exp;
        do_reset();
        for (int c = 0; c <= 100; c++) begin
            rst = (c == 30);
            enable = 1'b1;
            pat_load = (c == 12);
            pat_data = 16'hFFFF;
            if (c < 30) sb_q.push_back(exp_at(c, 16'h0005));
            else if (c == 30) sb_q.push_back(8'h00);
            else sb_q.push_back(exp_at(c - 31, 16'h0005));
            @(negedge clk);
            got = observed();
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rst_mid c=%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
        pat_load = 1'b0;
    endtask

    task automatic test_random_exclusive();
        int n_smp, n_tck, n_sng;
        do_reset();
        n_smp = 0;
        n_tck = 0;
        n_sng = 0;
        rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            enable = 1'($urandom_range(0, 1));
            pat_load = ($urandom_range(0, 31) == 0);
            pat_data = 16'($urandom);
            @(negedge clk);
            checks++;
            if ((sample_clk & tick_clk) !== 1'b0) begin
                errors++;
                $display("FAIL excl_st c=%0d got=%b%b exp=not both",
                         c, sample_clk, tick_clk);
            end
            checks++;
            if ((song_clk & !tick_clk) !== 1'b0) begin
                errors++;
                $display("FAIL excl_song c=%0d song=%b tick=%b exp=song->tick",
                         c, song_clk, tick_clk);
            end
            n_smp += int'(sample_clk);
            n_tck += int'(tick_clk);
            n_sng += int'(song_clk);
            next_cycle();
        end
        checks++;
        if (n_tck > n_smp / 2 || n_tck < n_smp / 2 - 1) begin
            errors++;
            $display("FAIL tick_count got=%0d exp=%0d..%0d",
                     n_tck, n_smp / 2 - 1, n_smp / 2);
        end
        checks++;
        if (n_sng != (n_tck + 2) / 3) begin
            errors++;
            $display("FAIL song_count got=%0d exp=%0d",
                     n_sng, (n_tck + 2) / 3);
        end
        enable = 1'b0;
        pat_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_freeze();
        test_restart();
        test_reset_mid();
        test_random_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
